// File: rtl/div_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_pkg
// Purpose  : Shared encodings for the EX-stage division sequencer: FSM state
//            codes, ready/start levels and the DIV/DIVU aluop codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package div_seq_pkg;

    // FSM state encodings
    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    // Result-valid levels
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // Start-request levels
    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    // ALU operation codes served by the divider
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    typedef enum logic [1:0] {
        ST_FREE   = DivFree,
        ST_BYZERO = DivByZero,
        ST_ON     = DivOn,
        ST_END    = DivEnd
    } div_state_e;

    // True when the EX aluop selects the division unit
    function automatic logic is_div_op(input logic [7:0] aluop);
        return (aluop == EXE_DIV_OP) || (aluop == EXE_DIVU_OP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_seq_step.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_step
// Purpose  : One restoring shift-subtract iteration. Trial-subtracts the
//            divisor from the upper window of the working register and
//            returns the next working-register value.
// Ports    : i_dividend [2W:0] current working register
//            i_divisor  [W-1:0] divisor magnitude
//            o_next     [2W:0] working register after this iteration
// Revision : 1.0 - initial release
// ============================================================================
module div_seq_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]  i_dividend,
    input  logic [WIDTH-1:0]  i_divisor,
    output logic [2*WIDTH:0]  o_next
);

    logic [WIDTH:0] w_diff;

    // Extra top bit acts as the borrow: set means the trial went negative
    assign w_diff = {1'b0, i_dividend[2*WIDTH-1:WIDTH]} - {1'b0, i_divisor};

    // Either path shifts left by one; the accepted difference replaces the
    // partial remainder and a quotient 1 enters at the bottom.
    assign o_next = w_diff[WIDTH]
                  ? {i_dividend[2*WIDTH-1:0], 1'b0}
                  : {w_diff[WIDTH-1:0], i_dividend[WIDTH-1:0], 1'b1};

endmodule
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_seq
// Purpose  : Multi-cycle DIV/DIVU sequencer for the EX stage. Runs WIDTH
//            restoring iterations, stalls the pipeline while busy and
//            returns {remainder, quotient} for the HI/LO write.
// Ports    : clk, rst          clock, synchronous active-high reset
//            start_i           division request, held until ready_o
//            annul_i           cancel in-flight division
//            signed_div_i      1 = DIV, 0 = DIVU
//            opdata1_i/2_i     dividend / divisor
//            result_o          {remainder, quotient}
//            ready_o           result valid
//            stallreq_o        stall request to pipeline control
// Revision : 1.0 - initial release
// ============================================================================
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stallreq_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH);

    div_state_e          r_state_q,    w_state_d;
    logic [CNT_W-1:0]    r_cnt_q,      w_cnt_d;
    logic [2*WIDTH:0]    r_dividend_q, w_dividend_d;
    logic [WIDTH-1:0]    r_divisor_q,  w_divisor_d;
    logic                r_signed_q,   w_signed_d;
    logic                r_neg1_q,     w_neg1_d;
    logic                r_neg2_q,     w_neg2_d;
    logic [2*WIDTH-1:0]  r_result_q,   w_result_d;
    logic                r_ready_q,    w_ready_d;

    logic [2*WIDTH:0]    w_step_next;
    logic                w_op1_neg, w_op2_neg;
    logic [WIDTH-1:0]    w_op1_mag, w_op2_mag;
    logic [WIDTH-1:0]    w_quot, w_rem, w_quot_fix, w_rem_fix;

    // Operand magnitudes at acceptance; only negative signed operands flip
    assign w_op1_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign w_op2_neg = signed_div_i & opdata2_i[WIDTH-1];
    assign w_op1_mag = w_op1_neg ? -opdata1_i : opdata1_i;
    assign w_op2_mag = w_op2_neg ? -opdata2_i : opdata2_i;

    // Final layout: remainder sits one bit above the quotient field
    assign w_quot     = r_dividend_q[WIDTH-1:0];
    assign w_rem      = r_dividend_q[2*WIDTH:WIDTH+1];
    assign w_quot_fix = (r_signed_q & (r_neg1_q ^ r_neg2_q)) ? -w_quot : w_quot;
    assign w_rem_fix  = (r_signed_q & r_neg1_q) ? -w_rem : w_rem;

    div_seq_step #(
        .WIDTH      (WIDTH)
    ) u_step (
        .i_dividend (r_dividend_q),
        .i_divisor  (r_divisor_q),
        .o_next     (w_step_next)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_cnt_d      = r_cnt_q;
        w_dividend_d = r_dividend_q;
        w_divisor_d  = r_divisor_q;
        w_signed_d   = r_signed_q;
        w_neg1_d     = r_neg1_q;
        w_neg2_d     = r_neg2_q;
        w_result_d   = r_result_q;
        w_ready_d    = r_ready_q;

        case (r_state_q)
            ST_FREE: begin
                w_ready_d  = DivResultNotReady;
                w_result_d = '0;
                if ((start_i == DivStart) && !annul_i) begin
                    if (opdata2_i == '0) begin
                        w_state_d = ST_BYZERO;
                    end else begin
                        w_state_d    = ST_ON;
                        w_cnt_d      = '0;
                        // Dividend enters pre-shifted so the first trial
                        // window holds its MSB.
                        w_dividend_d = {{WIDTH{1'b0}}, w_op1_mag, 1'b0};
                        w_divisor_d  = w_op2_mag;
                        w_signed_d   = signed_div_i;
                        w_neg1_d     = opdata1_i[WIDTH-1];
                        w_neg2_d     = opdata2_i[WIDTH-1];
                    end
                end
            end

            ST_BYZERO: begin
                w_result_d = '0;
                w_ready_d  = DivResultNotReady;
                w_state_d  = annul_i ? ST_FREE : ST_END;
            end

            ST_ON: begin
                if (annul_i) begin
                    w_state_d  = ST_FREE;
                    w_cnt_d    = '0;
                    w_result_d = '0;
                    w_ready_d  = DivResultNotReady;
                end else if (r_cnt_q != c_cnt_last) begin
                    w_dividend_d = w_step_next;
                    w_cnt_d      = r_cnt_q + CNT_W'(1);
                end else begin
                    w_state_d  = ST_END;
                    w_cnt_d    = '0;
                    w_result_d = {w_rem_fix, w_quot_fix};
                    w_ready_d  = DivResultReady;
                end
            end

            ST_END: begin
                if (annul_i || (start_i == DivStop)) begin
                    w_state_d  = ST_FREE;
                    w_result_d = '0;
                    w_ready_d  = DivResultNotReady;
                end else begin
                    // Divide-by-zero arrives here without ready raised yet;
                    // its zero result is published one edge later.
                    w_ready_d  = DivResultReady;
                end
            end

            default: begin
                w_state_d  = ST_FREE;
                w_cnt_d    = '0;
                w_result_d = '0;
                w_ready_d  = DivResultNotReady;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= ST_FREE;
            r_cnt_q      <= '0;
            r_dividend_q <= '0;
            r_divisor_q  <= '0;
            r_signed_q   <= 1'b0;
            r_neg1_q     <= 1'b0;
            r_neg2_q     <= 1'b0;
            r_result_q   <= '0;
            r_ready_q    <= DivResultNotReady;
        end else begin
            r_state_q    <= w_state_d;
            r_cnt_q      <= w_cnt_d;
            r_dividend_q <= w_dividend_d;
            r_divisor_q  <= w_divisor_d;
            r_signed_q   <= w_signed_d;
            r_neg1_q     <= w_neg1_d;
            r_neg2_q     <= w_neg2_d;
            r_result_q   <= w_result_d;
            r_ready_q    <= w_ready_d;
        end
    end

    assign result_o   = r_result_q;
    assign ready_o    = r_ready_q;
    assign stallreq_o = start_i & ~r_ready_q & ~annul_i;

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_seq
// Purpose  : Directed self-checking bench for div_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        stallreq_o;

    int n_cmp = 0;
    int n_err = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .stallreq_o   (stallreq_o)
    );

    always #5 clk = ~clk;

    // Runs one division with operands held; returns the result and the number
    // of edges after the accepting edge at which ready_o was seen (-1 if never).
    // Drops start_i for one edge before returning.
    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] res, output int lat);
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        lat          = -1;
        res          = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready_o === 1'b1) begin
                lat = i;
                res = result_o;
                break;
            end
        end
        start_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = '0; opdata2_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
        n_cmp++; if (result_o !== 64'h0) begin n_err++; $display("FAIL reset_result got=%h exp=0", result_o); end
        n_cmp++; if (stallreq_o !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", stallreq_o); end
    endtask

    task automatic test_divu();
        int stall_bad = 0;
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        #1;
        n_cmp++; if (stallreq_o !== 1'b1) begin n_err++; $display("FAIL divu_stall_e0 got=%b exp=1", stallreq_o); end
        for (int i = 0; i < 33; i++) begin
            @(posedge clk); #1;
            if (ready_o !== 1'b0 || stallreq_o !== 1'b1) stall_bad++;
        end
        n_cmp++; if (stall_bad !== 0) begin n_err++; $display("FAIL divu_busy bad_cycles=%0d exp=0", stall_bad); end
        @(posedge clk); #1;
        n_cmp++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL divu_ready got=%b exp=1", ready_o); end
        n_cmp++; if (result_o !== {32'h2, 32'hE}) begin n_err++; $display("FAIL divu_result got=%h exp=%h", result_o, {32'h2, 32'hE}); end
        n_cmp++; if (stallreq_o !== 1'b0) begin n_err++; $display("FAIL divu_stall_end got=%b exp=0", stallreq_o); end
        @(posedge clk); #1;
        n_cmp++; if (ready_o !== 1'b1 || result_o !== {32'h2, 32'hE}) begin n_err++; $display("FAIL divu_hold ready=%b res=%h exp=1/%h", ready_o, result_o, {32'h2, 32'hE}); end
        start_i = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (ready_o !== 1'b0 || result_o !== 64'h0) begin n_err++; $display("FAIL divu_release ready=%b res=%h exp=0/0", ready_o, result_o); end
    endtask

    task automatic test_signed();
        logic [63:0] res; int lat;
        do_div(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, res, lat);
        n_cmp++; if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD} || lat !== 33) begin n_err++; $display("FAIL div_m7_2 got=%h lat=%0d exp=%h lat=33", res, lat, {32'hFFFF_FFFF, 32'hFFFF_FFFD}); end
        do_div(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, res, lat);
        n_cmp++; if (res !== {32'h0000_0001, 32'hFFFF_FFFD} || lat !== 33) begin n_err++; $display("FAIL div_7_m2 got=%h lat=%0d exp=%h lat=33", res, lat, {32'h0000_0001, 32'hFFFF_FFFD}); end
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL signed_release ready=%b exp=0", ready_o); end
    endtask

    task automatic test_byzero_overflow();
        logic [63:0] res; int lat;
        do_div(1'b0, 32'd5, 32'd0, res, lat);
        n_cmp++; if (res !== 64'h0 || lat !== 2) begin n_err++; $display("FAIL byzero got=%h lat=%0d exp=0 lat=2", res, lat); end
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
        n_cmp++; if (res !== {32'h0, 32'h8000_0000} || lat !== 33) begin n_err++; $display("FAIL overflow got=%h lat=%0d exp=%h", res, lat, {32'h0, 32'h8000_0000}); end
        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
        n_cmp++; if (res !== {32'h8000_0000, 32'h0} || lat !== 33) begin n_err++; $display("FAIL divu_big got=%h lat=%0d exp=%h", res, lat, {32'h8000_0000, 32'h0}); end
    endtask

    task automatic test_annul_and_reset();
        logic [63:0] res; int lat; int ready_seen = 0;
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        annul_i = 1'b1;
        #1;
        n_cmp++; if (stallreq_o !== 1'b0) begin n_err++; $display("FAIL annul_stall got=%b exp=0", stallreq_o); end
        @(posedge clk); #1;
        annul_i = 1'b0; start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (ready_o !== 1'b0) ready_seen++;
            @(posedge clk); #1;
        end
        n_cmp++; if (ready_seen !== 0) begin n_err++; $display("FAIL annul_no_ready seen=%0d exp=0", ready_seen); end
        do_div(1'b0, 32'd50, 32'd5, res, lat);
        n_cmp++; if (res !== {32'h0, 32'd10} || lat !== 33) begin n_err++; $display("FAIL after_annul got=%h lat=%0d exp=%h lat=33", res, lat, {32'h0, 32'd10}); end

        opdata1_i = 32'd12345; opdata2_i = 32'd7; start_i = 1'b1;
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1; start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++; if (ready_o !== 1'b0 || result_o !== 64'h0 || stallreq_o !== 1'b0) begin n_err++; $display("FAIL midrst ready=%b res=%h stall=%b exp=0/0/0", ready_o, result_o, stallreq_o); end
        ready_seen = 0;
        for (int i = 0; i < 36; i++) begin
            @(posedge clk); #1;
            if (ready_o !== 1'b0) ready_seen++;
        end
        n_cmp++; if (ready_seen !== 0) begin n_err++; $display("FAIL midrst_idle seen=%0d exp=0", ready_seen); end
    endtask

    task automatic test_operand_stability();
        int lat = -1; logic [63:0] res = '0;
        signed_div_i = 1'b1; opdata1_i = 32'hFFFF_FF9C; opdata2_i = 32'd7; start_i = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready_o === 1'b1) begin lat = i; res = result_o; break; end
            opdata1_i    = $urandom;
            opdata2_i    = $urandom;
            signed_div_i = 1'($urandom_range(1, 0));
        end
        start_i = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (res !== {32'hFFFF_FFFE, 32'hFFFF_FFF2} || lat !== 33) begin n_err++; $display("FAIL stability got=%h lat=%0d exp=%h lat=33", res, lat, {32'hFFFF_FFFE, 32'hFFFF_FFF2}); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res; int lat;
        do_div(1'b0, 32'd9, 32'd4, res, lat);
        n_cmp++; if (res !== {32'h1, 32'h2} || lat !== 33) begin n_err++; $display("FAIL b2b_first got=%h lat=%0d exp=%h", res, lat, {32'h1, 32'h2}); end
        n_cmp++; if (ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_gap ready=%b exp=0", ready_o); end
        do_div(1'b0, 32'hFFFF_FFFF, 32'h10, res, lat);
        n_cmp++; if (res !== {32'hF, 32'h0FFF_FFFF} || lat !== 33) begin n_err++; $display("FAIL b2b_second got=%h lat=%0d exp=%h lat=33", res, lat, {32'hF, 32'h0FFF_FFFF}); end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_signed();
        test_byzero_overflow();
        test_annul_and_reset();
        test_operand_stability();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
